// File: rtl/gather_bus_pkg.sv
// Shared types and helpers for the gather bus (PE row -> GLB opsum readout).
package gather_bus_pkg;

  // Transfer FSM states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    OUTPUT  = 2'd2
  } state_e;

  // Default tag width and its reserved "no ID" value (all ones).
  localparam int ID_LEN_DEF = 4;
  localparam logic [ID_LEN_DEF-1:0] ID_NONE = '1;

  // Widest PE row the one-hot helper handles; callers size-cast in and out.
  localparam int MAX_SLAVES = 64;

  // Isolate the lowest set bit of v (all zeros when v is zero).
  function automatic logic [MAX_SLAVES-1:0] lowest_onehot(input logic [MAX_SLAVES-1:0] v);
    return v & (~v + MAX_SLAVES'(1));
  endfunction

endpackage

// File: rtl/gather_bus_if.sv
// Sink/PE-side signal bundle of the gather bus. The bus itself uses the
// slave modport; whoever drives tags, PE data and the ID chain uses master.
interface gather_bus_if #(
  parameter int SLAVE_NUMS = 14,
  parameter int ID_LEN     = 4,
  parameter int VALUE_LEN  = 32
);
  logic                                set_id;
  logic [ID_LEN-1:0]                   id_scan_in;
  logic [ID_LEN-1:0]                   id_scan_out;
  logic                                tag_enable;
  logic [ID_LEN-1:0]                   tag_in;
  logic                                tag_ready;
  logic [SLAVE_NUMS*(VALUE_LEN+1)-1:0] slave_enable_data;
  logic [SLAVE_NUMS-1:0]               slave_ready;
  logic [VALUE_LEN-1:0]                data_out;
  logic                                data_valid;
  logic                                data_ready;
  logic                                tag_miss;

  modport master (
    output set_id, id_scan_in, tag_enable, tag_in, slave_enable_data, data_ready,
    input  id_scan_out, tag_ready, slave_ready, data_out, data_valid, tag_miss
  );

  modport slave (
    input  set_id, id_scan_in, tag_enable, tag_in, slave_enable_data, data_ready,
    output id_scan_out, tag_ready, slave_ready, data_out, data_valid, tag_miss
  );
endinterface

// File: rtl/gather_id_chain.sv
// Serial ID scan chain across the PE row plus per-PE tag comparison.
// The first word shifted in ends up at the last PE after SLAVE_NUMS shifts.
module gather_id_chain
  import gather_bus_pkg::*;
#(
  parameter int SLAVE_NUMS = 14,
  parameter int ID_LEN     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_id_i,
  input  logic [ID_LEN-1:0]     scan_in_i,
  input  logic [ID_LEN-1:0]     tag_i,
  output logic [ID_LEN-1:0]     scan_out_o,
  output logic [SLAVE_NUMS-1:0] match_o
);

  localparam logic [ID_LEN-1:0] IdNone = {ID_LEN{1'b1}};

  logic [ID_LEN-1:0] id_q [SLAVE_NUMS];

  generate
    for (genvar gi = 0; gi < SLAVE_NUMS; gi++) begin : g_pe
      logic [ID_LEN-1:0] shift_src;

      if (gi == 0) begin : g_head
        assign shift_src = scan_in_i;
      end else begin : g_body
        assign shift_src = id_q[gi-1];
      end

      // Shift one position down the row while set_id is held.
      always_ff @(posedge clk) begin
        if (rst) begin
          id_q[gi] <= IdNone;
        end else if (set_id_i) begin
          id_q[gi] <= shift_src;
        end
      end

      // A reserved tag never matches, even against an unloaded PE.
      assign match_o[gi] = (tag_i != IdNone) && (id_q[gi] == tag_i);
    end
  endgenerate

  assign scan_out_o = id_q[SLAVE_NUMS-1];

endmodule

// File: rtl/gather_bus.sv
// Gather bus: the sink issues a tag, the bus handshakes with the PE(s) whose
// scan-loaded ID matches and forwards the value downstream.
// Build option GATHER_SUM_EN: reduce every matching PE (sum modulo
// 2^VALUE_LEN) instead of taking the lowest-index enabled match.
module gather_bus
  import gather_bus_pkg::*;
#(
  parameter int SLAVE_NUMS = 14,
  parameter int ID_LEN     = 4,
  parameter int VALUE_LEN  = 32
) (
  input  logic        clk,
  input  logic        rst,
  gather_bus_if.slave bus
);

  localparam int SLICE = VALUE_LEN + 1;

  state_e                state_q, state_d;
  logic [SLAVE_NUMS-1:0] pending_q, pending_d;
  logic [VALUE_LEN-1:0]  data_q, data_d;
`ifdef GATHER_SUM_EN
  logic [VALUE_LEN-1:0]  acc_q, acc_d;
`endif

  logic [SLAVE_NUMS-1:0] match;
  logic [SLAVE_NUMS-1:0] slave_en;
  logic [VALUE_LEN-1:0]  slave_data [SLAVE_NUMS];
  logic [SLAVE_NUMS-1:0] grant;
  logic [VALUE_LEN-1:0]  gathered;
  logic                  tag_ready;
  logic                  tag_miss;
  logic                  data_valid;
  logic                  active;

  gather_id_chain #(
    .SLAVE_NUMS(SLAVE_NUMS),
    .ID_LEN    (ID_LEN)
  ) u_id_chain (
    .clk       (clk),
    .rst       (rst),
    .set_id_i  (bus.set_id),
    .scan_in_i (bus.id_scan_in),
    .tag_i     (bus.tag_in),
    .scan_out_o(bus.id_scan_out),
    .match_o   (match)
  );

  // Split the packed per-PE {enable, data} slices.
  generate
    for (genvar gi = 0; gi < SLAVE_NUMS; gi++) begin : g_unpack
      assign slave_en[gi]   = bus.slave_enable_data[gi*SLICE + VALUE_LEN];
      assign slave_data[gi] = bus.slave_enable_data[gi*SLICE +: VALUE_LEN];
    end
  endgenerate

  // Reset and ID loading both suppress every handshake and abort transfers.
  assign active = !rst && !bus.set_id;

  // Next-state, PE selection and handshake outputs.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    data_d    = data_q;
`ifdef GATHER_SUM_EN
    acc_d     = acc_q;
`endif
    grant     = '0;
    gathered  = '0;
    tag_ready = 1'b0;
    tag_miss  = 1'b0;

    case (state_q)
      IDLE: begin
        tag_ready = active;
        if (active && bus.tag_enable) begin
          state_d   = COLLECT;
          pending_d = match;
          data_d    = '0;
`ifdef GATHER_SUM_EN
          acc_d     = '0;
`endif
        end
      end

      COLLECT: begin
        if (!active) begin
          state_d   = IDLE;
          pending_d = '0;
        end else if (pending_q == '0) begin
          tag_miss = 1'b1;
          state_d  = IDLE;
        end else begin
`ifdef GATHER_SUM_EN
          // Every pending PE that is enabled now is taken this cycle.
          grant    = pending_q & slave_en;
          gathered = acc_q;
          for (int i = 0; i < SLAVE_NUMS; i++) begin
            if (grant[i]) begin
              gathered = gathered + slave_data[i];
            end
          end
          acc_d     = gathered;
          pending_d = pending_q & ~grant;
          if (pending_d == '0) begin
            data_d  = gathered;
            state_d = OUTPUT;
          end
`else
          // Only the lowest-index enabled match is taken.
          grant = SLAVE_NUMS'(lowest_onehot(MAX_SLAVES'(pending_q & slave_en)));
          for (int i = 0; i < SLAVE_NUMS; i++) begin
            if (grant[i]) begin
              gathered = gathered | slave_data[i];
            end
          end
          if (grant != '0) begin
            data_d    = gathered;
            pending_d = '0;
            state_d   = OUTPUT;
          end
`endif
        end
      end

      OUTPUT: begin
        if (bus.set_id) begin
          state_d = IDLE;
          data_d  = '0;
        end else if (bus.data_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      data_q    <= '0;
`ifdef GATHER_SUM_EN
      acc_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      data_q    <= data_d;
`ifdef GATHER_SUM_EN
      acc_q     <= acc_d;
`endif
    end
  end

  assign data_valid      = !rst && (state_q == OUTPUT);
  assign bus.data_valid  = data_valid;
  assign bus.data_out    = data_valid ? data_q : '0;
  assign bus.tag_ready   = tag_ready;
  assign bus.tag_miss    = tag_miss;
  assign bus.slave_ready = grant;

endmodule

// File: tb/tb_gather_bus.sv
// Self-checking bench for gather_bus: directed scenarios followed by random
// transactions, all compared against a transaction-level model of the bus.
module tb_gather_bus;
  import gather_bus_pkg::*;

  localparam int SN = 14;
  localparam int IL = 4;
  localparam int VL = 32;
  localparam int W  = VL + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gather_bus_if #(.SLAVE_NUMS(SN), .ID_LEN(IL), .VALUE_LEN(VL)) bus ();

  gather_bus #(.SLAVE_NUMS(SN), .ID_LEN(IL), .VALUE_LEN(VL)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [IL-1:0] model_id [SN];
  logic [SN-1:0] en_pat;
  logic [VL-1:0] dat_pat [SN];

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_slaves(input logic [SN-1:0] en);
    logic [SN*W-1:0] v;
    for (int i = 0; i < SN; i++) v[i*W +: W] = {en[i], dat_pat[i]};
    bus.slave_enable_data = v;
  endtask

  task automatic model_reset();
    for (int i = 0; i < SN; i++) model_id[i] = ID_NONE;
  endtask

  function automatic logic [SN-1:0] model_mask(input logic [IL-1:0] tag);
    logic [SN-1:0] m;
    m = '0;
    for (int i = 0; i < SN; i++) m[i] = (tag != ID_NONE) && (model_id[i] == tag);
    return m;
  endfunction

  // Which PEs the bus should ready, given outstanding matches and enables.
  function automatic logic [SN-1:0] exp_grant(input logic [SN-1:0] pend, input logic [SN-1:0] en);
    logic [SN-1:0] one;
    one = 1;
`ifdef GATHER_SUM_EN
    return pend & en;
`else
    for (int i = 0; i < SN; i++) if (pend[i] && en[i]) return one << i;
    return '0;
`endif
  endfunction

  // Shift a sequence of IDs in (element 0 first) and track it in the model.
  task automatic load_ids(input logic [IL-1:0] vals [SN]);
    for (int k = 0; k < SN; k++) begin
      bus.set_id     = 1'b1;
      bus.id_scan_in = vals[k];
      settle();
      chk("tag_ready_during_set_id", 64'(bus.tag_ready), 64'(0));
      cyc();
      for (int i = SN - 1; i > 0; i--) model_id[i] = model_id[i-1];
      model_id[0] = vals[k];
    end
    bus.set_id = 1'b0;
    settle();
    chk("id_scan_out_after_load", 64'(bus.id_scan_out), 64'(model_id[SN-1]));
  endtask

  // PE i gets ID i%7: shift 6,5,..,0,6,..,0.
  task automatic load_mod7();
    logic [IL-1:0] v [SN];
    for (int k = 0; k < SN; k++) v[k] = IL'((SN - 1 - k) % 7);
    load_ids(v);
  endtask

  task automatic load_random();
    logic [IL-1:0] v [SN];
    for (int k = 0; k < SN; k++) begin
      v[k] = IL'($urandom_range(0, 6));
      if ($urandom_range(0, 5) == 0) v[k] = ID_NONE;
    end
    load_ids(v);
  endtask

  // One full tag transaction. quiet: cycles in COLLECT with only non-matching
  // PEs enabled; rnd: random enables/data, else en_pat then all enabled.
  task automatic run_txn(input logic [IL-1:0] tag, input int quiet, input bit rnd, input int stall);
    logic [SN-1:0] pend, first, en, g;
    logic [VL-1:0] acc;
    bit            done;
    int            k;
    bus.tag_enable = 1'b1;
    bus.tag_in     = tag;
    settle();
    chk("tag_ready_idle", 64'(bus.tag_ready), 64'(1));
    pend  = model_mask(tag);
    first = pend;
    cyc();
    bus.tag_enable = 1'b0;
    bus.tag_in     = IL'($urandom);
    if (pend == '0) begin
      drive_slaves('1);
      settle();
      chk("tag_miss_pulse", 64'(bus.tag_miss), 64'(1));
      chk("miss_slave_ready", 64'(bus.slave_ready), 64'(0));
      chk("miss_data_valid", 64'(bus.data_valid), 64'(0));
      cyc();
      drive_slaves('0);
      settle();
      chk("tag_miss_clear", 64'(bus.tag_miss), 64'(0));
      chk("tag_ready_after_miss", 64'(bus.tag_ready), 64'(1));
      return;
    end
    acc  = '0;
    done = 1'b0;
    k    = 0;
    while (!done) begin
      if (k < quiet) en = ~first;
      else if (k >= quiet + 8) en = '1;
      else if (rnd) begin
        en = SN'($urandom);
        for (int i = 0; i < SN; i++) dat_pat[i] = VL'($urandom);
      end
      else if (k == quiet) en = en_pat;
      else en = '1;
      drive_slaves(en);
      settle();
      g = exp_grant(pend, en);
      chk("slave_ready", 64'(bus.slave_ready), 64'(g));
      chk("collect_tag_miss", 64'(bus.tag_miss), 64'(0));
      chk("collect_data_valid", 64'(bus.data_valid), 64'(0));
      chk("collect_tag_ready", 64'(bus.tag_ready), 64'(0));
      for (int i = 0; i < SN; i++) if (g[i]) acc = acc + dat_pat[i];
      pend = pend & ~g;
`ifdef GATHER_SUM_EN
      done = (pend == '0);
`else
      done = (g != '0);
`endif
      cyc();
      k++;
      if (k >= 40) begin
        chk("collect_cycle_budget", 64'(k), 64'(0));
        done = 1'b1;
      end
    end
    drive_slaves('0);
    bus.data_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      settle();
      chk("stall_data_valid", 64'(bus.data_valid), 64'(1));
      chk("stall_data_out", 64'(bus.data_out), 64'(acc));
      chk("stall_tag_ready", 64'(bus.tag_ready), 64'(0));
      chk("stall_slave_ready", 64'(bus.slave_ready), 64'(0));
      cyc();
    end
    bus.data_ready = 1'b1;
    settle();
    chk("data_valid", 64'(bus.data_valid), 64'(1));
    chk("data_out", 64'(bus.data_out), 64'(acc));
    cyc();
    bus.data_ready = 1'b0;
    settle();
    chk("valid_drop", 64'(bus.data_valid), 64'(0));
    chk("tag_ready_next", 64'(bus.tag_ready), 64'(1));
    $display("[TB] txn tag=%0d data=0x%0h collect_cycles=%0d stall=%0d", tag, acc, k, stall);
  endtask

  initial begin
    logic [IL-1:0] t;
    rst                   = 1'b1;
    bus.set_id            = 1'b0;
    bus.id_scan_in        = '0;
    bus.tag_enable        = 1'b0;
    bus.tag_in            = '0;
    bus.data_ready        = 1'b0;
    en_pat                = '0;
    for (int i = 0; i < SN; i++) dat_pat[i] = VL'($urandom);
    drive_slaves('0);
    model_reset();

    // Reset state.
    cyc();
    cyc();
    chk("rst_tag_ready", 64'(bus.tag_ready), 64'(0));
    chk("rst_data_valid", 64'(bus.data_valid), 64'(0));
    chk("rst_data_out", 64'(bus.data_out), 64'(0));
    chk("rst_slave_ready", 64'(bus.slave_ready), 64'(0));
    chk("rst_tag_miss", 64'(bus.tag_miss), 64'(0));
    chk("rst_id_scan_out", 64'(bus.id_scan_out), 64'(ID_NONE));
    rst = 1'b0;
    cyc();
    chk("tag_ready_after_rst", 64'(bus.tag_ready), 64'(1));

    // Any tag before an ID load misses.
    run_txn(4'd5, 0, 1'b0, 0);

    load_mod7();

    // Tag 3: PE3 and PE10 both enabled.
    dat_pat[3]  = 32'h11;
    dat_pat[10] = 32'h22;
    en_pat      = (SN'(1) << 3) | (SN'(1) << 10);
    run_txn(4'd3, 0, 1'b0, 0);

    // Tag 2: five cycles without a matching enable, then PE9.
    dat_pat[9] = 32'hABCD;
    dat_pat[2] = 32'h1;
    en_pat     = SN'(1) << 9;
    run_txn(4'd2, 5, 1'b0, 0);

    // Reserved tag always misses.
    run_txn(ID_NONE, 0, 1'b0, 0);

    // Sink stall for four cycles.
    dat_pat[4]  = 32'h4444_0004;
    dat_pat[11] = 32'h1111_000B;
    en_pat      = (SN'(1) << 4) | (SN'(1) << 11);
    run_txn(4'd4, 0, 1'b0, 4);

    // set_id while in COLLECT aborts without a handshake.
    bus.tag_enable = 1'b1;
    bus.tag_in     = 4'd1;
    cyc();
    bus.tag_enable = 1'b0;
    bus.set_id     = 1'b1;
    bus.id_scan_in = 4'd5;
    drive_slaves('1);
    settle();
    chk("abort_slave_ready", 64'(bus.slave_ready), 64'(0));
    chk("abort_tag_ready", 64'(bus.tag_ready), 64'(0));
    chk("abort_tag_miss", 64'(bus.tag_miss), 64'(0));
    cyc();
    for (int i = SN - 1; i > 0; i--) model_id[i] = model_id[i-1];
    model_id[0]    = 4'd5;
    bus.set_id     = 1'b0;
    drive_slaves('0);
    settle();
    chk("abort_idle_tag_ready", 64'(bus.tag_ready), 64'(1));
    chk("abort_data_valid", 64'(bus.data_valid), 64'(0));
    chk("abort_chain_shift", 64'(bus.id_scan_out), 64'(model_id[SN-1]));
    $display("[TB] set_id abort in COLLECT");

    // Reset during COLLECT: no handshake in the reset cycle.
    bus.tag_enable = 1'b1;
    bus.tag_in     = 4'd1;
    cyc();
    bus.tag_enable = 1'b0;
    drive_slaves('1);
    rst = 1'b1;
    settle();
    chk("rst_collect_slave_ready", 64'(bus.slave_ready), 64'(0));
    cyc();
    rst = 1'b0;
    drive_slaves('0);
    model_reset();
    settle();
    chk("rst_collect_tag_ready", 64'(bus.tag_ready), 64'(1));
    chk("rst_collect_id_none", 64'(bus.id_scan_out), 64'(ID_NONE));
    $display("[TB] reset during COLLECT");

    // Reset during OUTPUT.
    load_mod7();
    bus.tag_enable = 1'b1;
    bus.tag_in     = 4'd0;
    cyc();
    bus.tag_enable = 1'b0;
    drive_slaves('1);
    cyc();
    drive_slaves('0);
    settle();
    chk("pre_rst_data_valid", 64'(bus.data_valid), 64'(1));
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    model_reset();
    settle();
    chk("post_rst_data_valid", 64'(bus.data_valid), 64'(0));
    chk("post_rst_tag_ready", 64'(bus.tag_ready), 64'(1));
    $display("[TB] reset during OUTPUT");

    // Tag 1: PE1 and PE8 carry values that wrap when summed.
    load_mod7();
    dat_pat[1] = 32'hFFFF_FFFF;
    dat_pat[8] = 32'h2;
    en_pat     = (SN'(1) << 1) | (SN'(1) << 8);
    run_txn(4'd1, 0, 1'b0, 1);

    // Random transactions.
    for (int n = 0; n < 40; n++) begin
      if (n % 10 == 0) load_random();
      t = IL'($urandom_range(0, 7));
      if (t == 4'd7) t = ID_NONE;
      run_txn(t, $urandom_range(0, 2), 1'b1, $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard time bound so the bench always terminates.
  initial begin
    #500000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/gather_bus.md
Name: gather_bus

Overview:
- Many-to-one counterpart of the tagged multicast bus: collects values from a row of PEs and delivers them to one sink (GLB side), for opsum readout.
- The sink issues a tag. The bus selects the PE whose scan-loaded ID matches the tag, completes an enable/ready handshake with that PE, and forwards the value downstream.
- Sits between one PE row's opsum ports and the GLB write path. IDs are loaded through the same serial ID scan chain style as the multicast bus.

Parameters:
- SLAVE_NUMS, 14, number of PEs on the bus.
- ID_LEN, 4, tag/ID width. The all-ones value is reserved as ID_NONE.
- VALUE_LEN, 32, data width (psum width).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- set_id  in  1  shift enable for the ID scan chain.
- id_scan_in  in  ID_LEN  scan chain serial input.
- id_scan_out  out  ID_LEN  scan chain serial output (last PE's ID).
- tag_enable  in  1  sink tag request valid.
- tag_in  in  ID_LEN  requested ID.
- tag_ready  out  1  bus can accept a tag.
- slave_enable_data  in  SLAVE_NUMS*(VALUE_LEN+1)  per PE: bit VALUE_LEN is enable, low bits are data; PE i occupies slice i.
- slave_ready  out  SLAVE_NUMS  per-PE ready (handshake fires on enable&ready).
- data_out  out  VALUE_LEN  gathered value.
- data_valid  out  1  data_out valid.
- data_ready  in  1  sink accepts data_out.
- tag_miss  out  1  one-cycle pulse: accepted tag matched no PE.

Behaviour:
- ID chain:
  - When set_id=1: id[0]<=id_scan_in, id[i]<=id[i-1].
  - id_scan_out=id[SLAVE_NUMS-1].
  - Reset sets every id to ID_NONE.
  - Loading needs SLAVE_NUMS cycles; the first word shifted in ends at PE SLAVE_NUMS-1.
- FSM states: IDLE, COLLECT, OUTPUT.
- IDLE:
  - tag_ready=1.
  - On tag_enable&tag_ready, latch tag and compute match mask (id[i]==tag, i.e. id==tag and tag!=ID_NONE); go to COLLECT.
- COLLECT:
  - If the mask is empty: pulse tag_miss for this cycle and return to IDLE.
  - Otherwise, select the lowest-index PE i with mask[i] & enable[i]. Drive slave_ready[i]=1 combinationally in that same cycle, latch its data into data_out, and go to OUTPUT.
  - If no matching PE has enable, stay in COLLECT with all slave_ready=0; no timeout.
- OUTPUT:
  - data_valid=1, data_out held stable.
  - On data_ready, go to IDLE.
- slave_ready is never asserted outside COLLECT and goes to at most one PE per cycle (base build).
- Latency: tag accepted at cycle T; PE handshake at T+1 at the earliest; data_valid at T+2; next tag accepted at T+3 at the earliest (IDLE, after data_ready at T+2).
- Reset values: tag_ready=0 during reset, becomes 1 in the cycle after rst falls. All other outputs are 0. id_scan_out=ID_NONE.
- set_id=1 while not in IDLE: the FSM aborts to IDLE next cycle. Any latched data is discarded and data_valid drops next cycle. tag_ready=0 while set_id=1.
- A tag whose value equals ID_NONE is accepted and always produces tag_miss.
- Sink stall (data_ready=0): remain in OUTPUT indefinitely; PEs are not handshaken.
- Reset mid-transfer: the PE handshake does not occur in the reset cycle; all state clears.

Optional Feature:
- Macro GATHER_SUM_EN.
- With the macro:
  - COLLECT reduces all matching PEs: each matching PE is handshaken once, when it asserts enable.
  - A pending mask is tracked, and the values are accumulated modulo 2^VALUE_LEN.
  - Multiple PEs may be readied in the same cycle; their values are summed in that cycle.
  - Go to OUTPUT once the pending mask is empty; data_out is the sum.
- Without the macro: lowest-index single gather, as described above.

Decomposition:
- Package gather_bus_pkg:
  - state enum (IDLE, COLLECT, OUTPUT).
  - ID_NONE constant.
  - helper function for the lowest-set-bit one-hot.
- Sub-module gather_id_chain: the ID scan-chain shift register plus per-PE compare, outputting the match mask.

Test Plan:
- Load IDs 6..0 twice (14 shifts). Tag 3 requested; PE3 and PE10 both enable with 0x11/0x22 -> slave_ready to PE3 only; data_out=0x11; data_valid at T+2.
- Tag 2 accepted, no PE enabled for 5 cycles, then PE9 enables with 0xABCD -> slave_ready stays 0 for 5 cycles; data_out=0xABCD.
- Tag 15 (ID_NONE), or any tag after reset without an ID load -> tag_miss pulses 1 cycle; no slave_ready; tag_ready back at 1.
- data_ready held 0 for 4 cycles in OUTPUT -> data_valid and data_out stable; tag_ready=0 throughout.
- set_id asserted while in COLLECT -> IDLE next cycle, no handshake, chain shifts; rst pulse in OUTPUT -> data_valid=0 next cycle.
- GATHER_SUM_EN: tag 1, PE1=0xFFFFFFFF and PE8=0x2 -> data_out=0x1 (wrap); each PE readied exactly once.
